// File: rtl/rom_mult_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential ROM-based multiplier.
interface rom_mult_seq_ctrl_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = 2 * N;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod;

    // Operand source / result consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    // Multiplier controller side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/rom_mult_seq_ctrl.sv
// N x N unsigned multiplier built from one 2x2 lookup ROM, one digit pair per cycle.
module rom_mult_seq_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rom_mult_seq_ctrl_if.slave  bus,
    output logic                busy
);
    localparam int unsigned K  = N / 2;
    localparam int unsigned W  = 2 * N;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [W-1:0]    acc;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [1:0]      a_dig;
    logic [1:0]      b_dig;
    logic [3:0]      rom_prod;
    logic [IW+1:0]   shamt;
    logic [W-1:0]    acc_sum;
    logic            last;
    logic            zero_op;
    logic            in_ready_next;
    logic            out_valid_next;
    logic            busy_next;

    // Digit selection, partial product alignment and termination conditions
    always_comb begin
        a_dig   = 2'(a_q >> {i, 1'b0});
        b_dig   = 2'(b_q >> {j, 1'b0});
        shamt   = {(IW + 1)'(i) + (IW + 1)'(j), 1'b0};
        acc_sum = acc + (W'(rom_prod) << shamt);
        last    = (i == IW'(K - 1)) && (j == IW'(K - 1));
        zero_op = (a_q == '0) || (b_q == '0);
    end

    // 2x2 multiplier lookup table, indexed by {a_dig, b_dig}
    always_comb begin
        rom_prod = 4'd0;
        case ({a_dig, b_dig})
            4'h5:    rom_prod = 4'd1;
            4'h6:    rom_prod = 4'd2;
            4'h7:    rom_prod = 4'd3;
            4'h9:    rom_prod = 4'd2;
            4'hA:    rom_prod = 4'd4;
            4'hB:    rom_prod = 4'd6;
            4'hD:    rom_prod = 4'd3;
            4'hE:    rom_prod = 4'd6;
            4'hF:    rom_prod = 4'd9;
            default: rom_prod = 4'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero operand is detected on the registered copy and skips the digit loop
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (zero_op || last) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake flags are registered
    always_comb begin
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
        busy_next      = (state_next != IDLE);
    end

    // Registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.in_ready  <= in_ready_next;
            bus.out_valid <= out_valid_next;
            busy          <= busy_next;
        end
    end

    // Operand capture, digit walk, shift-accumulate and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            bus.prod <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                RUN: begin
                    if (zero_op) begin
                        bus.prod <= '0;
                    end else begin
                        acc <= acc_sum;
                        if (j == IW'(K - 1)) begin
                            j <= '0;
                            i <= i + IW'(1);
                        end else begin
                            j <= j + IW'(1);
                        end
                        if (last) begin
                            bus.prod <= acc_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_mult_seq_ctrl.sv
// Directed self-checking bench for the sequential ROM multiplier at N = 8 and N = 4.
module tb_rom_mult_seq_ctrl;
    logic clk;
    logic rst_n;
    logic busy8;
    logic busy4;
    int   checks;
    int   errors;

    rom_mult_seq_ctrl_if #(.N(8)) bus8 ();
    rom_mult_seq_ctrl_if #(.N(4)) bus4 ();

    rom_mult_seq_ctrl #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8),
        .busy  (busy8)
    );

    rom_mult_seq_ctrl #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4),
        .busy  (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle on the chosen instance
    task automatic drive(input bit n4, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        if (n4) begin
            bus4.a = av[3:0];
            bus4.b = bv[3:0];
            bus4.in_valid = 1'b1;
        end else begin
            bus8.a = av;
            bus8.b = bv;
            bus8.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, bounded
    task automatic wait_result(input bit n4, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(n4 ? bus4.out_valid : bus8.out_valid) && lat < 100);
    endtask

    // Full transaction with out_ready held high
    task automatic run_mul(input bit n4, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] exp_prod, input int exp_lat, input string tag);
        int lat;
        drive(n4, av, bv);
        check({tag, "_rdy_low"}, 32'(n4 ? bus4.in_ready : bus8.in_ready), 32'd0);
        wait_result(n4, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_prod"}, 32'(n4 ? {8'd0, bus4.prod} : bus8.prod), 32'(exp_prod));
        @(posedge clk);
        #1;
        check({tag, "_rdy_back"}, 32'(n4 ? bus4.in_ready : bus8.in_ready), 32'd1);
        check({tag, "_ov_drop"}, 32'(n4 ? bus4.out_valid : bus8.out_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_prod", 32'(bus8.prod), 32'd0);
        check("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul(1'b0, 8'h03, 8'h05, 16'h000F, 16, "m03x05");
        run_mul(1'b0, 8'hFF, 8'hFF, 16'hFE01, 16, "mFFxFF");
        run_mul(1'b0, 8'hAB, 8'hCD, 16'h88EF, 16, "mABxCD");
        run_mul(1'b0, 8'h00, 8'hAB, 16'h0000, 1, "m00xAB");
        run_mul(1'b0, 8'h5A, 8'h00, 16'h0000, 1, "m5Ax00");

        // Backpressure: result held while the consumer stalls, stray operands ignored
        bus8.out_ready = 1'b0;
        drive(1'b0, 8'h12, 8'h34);
        wait_result(1'b0, lat);
        check("bp_lat", 32'(lat), 32'd16);
        check("bp_prod", 32'(bus8.prod), 32'h03A8);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                drive(1'b0, 8'h77, 8'h11);
            end else begin
                @(posedge clk);
                #1;
            end
            check("bp_hold_ov", 32'(bus8.out_valid), 32'd1);
            check("bp_hold_prod", 32'(bus8.prod), 32'h03A8);
            check("bp_hold_rdy", 32'(bus8.in_ready), 32'd0);
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rdy_back", 32'(bus8.in_ready), 32'd1);
        check("bp_ov_drop", 32'(bus8.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_stray_ignored", 32'(busy8), 32'd0);

        // Asynchronous reset in the middle of a run
        drive(1'b0, 8'hFF, 8'hFF);
        repeat (6) @(posedge clk);
        #2;
        check("mid_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(bus8.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_rdy", 32'(bus8.in_ready), 32'd1);
        check("mid_rst_prod", 32'(bus8.prod), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mul(1'b0, 8'h02, 8'h03, 16'h0006, 16, "m02x03");

        run_mul(1'b1, 8'h0F, 8'h0F, 16'h00E1, 4, "n4_FxF");
        run_mul(1'b1, 8'h09, 8'h06, 16'h0036, 4, "n4_9x6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_mult_seq_ctrl.md
# rom_mult_seq_ctrl

Sequencing controller that computes an N×N unsigned product by time-multiplexing a single instance of the team's 2×2 ROM multiplier (2-bit a, 2-bit b → 4-bit lookup product). It splits both operands into 2-bit digits, issues one digit pair per cycle to the ROM, and shift-accumulates the partial products. Upstream and downstream both connect through valid/ready handshakes. The block sits between the operand source and the result consumer wherever a wide multiply is needed without a full-width multiplier.

## Interface
- N, default 8: operand width in bits; must be even and ≥ 4. K = N/2 is the digit count per operand.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  controller can accept operands. High only in IDLE.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- out_valid  output  1  prod holds a completed result. High only in DONE.
- out_ready  input  1  consumer accepts prod.
- prod  output  2N  unsigned product a×b, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; there are no illegal-state hazards, and unused encodings return to IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - register a and b;
  - clear acc (2N bits);
  - clear digit indices i (a-digit) and j (b-digit);
  - if a == 0 or b == 0, go to DONE with acc = 0 (zero early-out);
  - otherwise go to RUN.
- RUN, each cycle:
  - drive the ROM with a[2i+1:2i] and b[2j+1:2j];
  - acc ← acc + (rom_prod zero-extended to 2N) << (2·(i+j));
  - j increments; on j == K−1, j wraps to 0 and i increments.
  - The cycle with i == j == K−1 performs the final accumulate and transitions to DONE.
- Arithmetic: acc is 2N bits wide. It never overflows, because the maximum product (2^N−1)² < 2^(2N). The shift amount ranges 0..2N−4.
- DONE: out_valid = 1 and prod = acc, held stable until out_ready. On out_ready, go to IDLE; out_valid drops the next cycle.
- in_valid during RUN or DONE is ignored, because in_ready = 0. Operands must be held by the source until accepted.
- The ROM instance is purely combinational. Its output is consumed in the same cycle and is not registered.
- Reset, asynchronous assertion at any time including mid-RUN or in DONE:
  - state = IDLE, i = j = 0, acc = 0;
  - registered a and b = 0;
  - any result in flight is discarded.
- Reset values of outputs: in_ready = 1 (combinational from IDLE), out_valid = 0, busy = 0, prod = 0.

## Timing
- Operand accept at rising edge E (in_valid && in_ready sampled high).
- Non-zero operands:
  - RUN occupies edges E+1 .. E+K²;
  - out_valid is high after edge E+K²;
  - latency is K² cycles (16 for N = 8, 4 for N = 4).
- Zero operand: out_valid is high after edge E+1 (1-cycle latency).
- Result accept at edge F (out_valid && out_ready): in_ready is high after F. The earliest next accept is edge F+1.
- Throughput, non-zero: one result per K²+2 cycles with out_ready held high.
- out_ready is ignored outside DONE. A simultaneous in_valid in the DONE cycle is not accepted; it is taken on the following IDLE cycle.
- prod changes only on entry to DONE and on reset. It holds its last value through IDLE and RUN, but is valid only while out_valid is high.

## Test plan
- N = 8, a = 0x03, b = 0x05, out_ready = 1 → out_valid exactly 16 cycles after accept, prod = 0x000F; in_ready returns 1 the cycle after the handshake.
- N = 8, a = 0xFF, b = 0xFF → prod = 0xFE01 after 16 cycles; a = 0xAB, b = 0xCD → prod = 0x88EF.
- N = 8, a = 0x00, b = 0xAB → out_valid 1 cycle after accept, prod = 0x0000; likewise a = 0x5A, b = 0x00 → 0x0000.
- Backpressure, N = 8: a = 0x12, b = 0x34 with out_ready held low 5 cycles after out_valid → prod = 0x03A8 held stable, out_valid stays high, and in_ready stays 0. A second in_valid pulse in that window is not accepted.
- Reset mid-RUN: assert rst_n = 0 at cycle 7 of a 0xFF×0xFF run → out_valid = 0, busy = 0, in_ready = 1 immediately (asynchronous). A following 0x02×0x03 yields prod = 0x0006 with no residue from the aborted run.
- Parameter N = 4: a = 0xF, b = 0xF → prod = 0xE1 after 4 cycles; a = 0x9, b = 0x6 → prod = 0x36.
